// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the iterative restoring divider.
// Combinational content only (types and constants), no latency.
// No flow control; consumed by the divider datapath and FSM.
package alu_div_seq_pkg;

   localparam int DIV_WIDTH = 16;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_sub_cla.sv
// (WIDTH+1)-bit borrow-lookahead subtractor, a - b computed as a + ~b + 1.
// Purely combinational, zero cycles.
// No flow control; result is valid whenever the inputs are stable.
module div_sub_cla
   import alu_div_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   output logic [WIDTH:0] diff,
   output logic           borrow
);

   // Pad to a whole number of 4-bit groups; zero extension keeps a - b exact.
   localparam int PW = WIDTH + 4;
   localparam int NG = PW / 4;

   logic [PW-1:0] a_x;
   logic [PW-1:0] b_n;
   logic [PW-1:0] g;
   logic [PW-1:0] p;
   logic [PW-1:0] c;
   logic [PW-1:0] s;
   logic [NG:0]   gc;
   logic [2:0]    pad_unused;

   assign a_x   = {3'b000, a};
   assign b_n   = ~{3'b000, b};
   assign g     = a_x & b_n;
   assign p     = a_x ^ b_n;
   assign gc[0] = 1'b1;   // the +1 of two's-complement negation

   for (genvar k = 0; k < NG; k++) begin : g_grp
      localparam int B = 4 * k;
      logic grp_g;
      logic grp_p;

      assign c[B]   = gc[k];
      assign c[B+1] = g[B] | (p[B] & gc[k]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[k]);

      assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                   | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p = p[B+3] & p[B+2] & p[B+1] & p[B];

      assign gc[k+1] = grp_g | (grp_p & gc[k]);
   end

   assign s          = p ^ c;
   assign diff       = s[WIDTH:0];
   assign pad_unused = s[PW-1:WIDTH+1];
   // Carry out of the padded word is set exactly when a >= b.
   assign borrow     = ~gc[NG];

endmodule

// File: rtl/alu_div_seq.sv
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned.
// done WIDTH+1 cycles after start (1 cycle for divide-by-zero).
// busy is high while a divide runs; start is ignored unless the FSM is idle.
module alu_div_seq
   import alu_div_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_by_zero_q, div_by_zero_d;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             trial_borrow;
   logic             trial_top_unused;

   assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + ONE_W) : dividend;
   assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? (~divisor + ONE_W)  : divisor;

   // Partial remainder shifted left with the next dividend bit brought in.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};

   div_sub_cla #(.WIDTH(WIDTH)) u_sub (
      .a      (rem_sh),
      .b      ({1'b0, dvs_q}),
      .diff   (trial),
      .borrow (trial_borrow)
   );

   // A successful trial is always below the divisor, so the top bit is zero.
   assign trial_top_unused = trial[WIDTH];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: divide-by-zero skips the iterations entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = (divisor == '0) ? ST_FIX : ST_CALC;
         ST_CALC: if (count_q == CW'(1)) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values for each state.
   always_comb begin
      count_d       = count_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      dvs_d         = dvs_q;
      neg_quo_d     = neg_quo_q;
      neg_rem_d     = neg_rem_q;
      dbz_d         = dbz_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      div_by_zero_d = div_by_zero_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               if (divisor == '0) begin
                  // Preload the final answer; FIX then passes it through untouched.
                  quo_d     = '1;
                  rem_d     = dividend;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  dbz_d     = 1'b1;
               end else begin
                  quo_d     = dvd_mag;
                  rem_d     = '0;
                  dvs_d     = dvs_mag;
                  count_d   = CW'(WIDTH);
                  neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  neg_rem_d = is_signed & dividend[WIDTH-1];
                  dbz_d     = 1'b0;
               end
            end
         end
         ST_CALC: begin
            count_d = count_q - CW'(1);
            if (!trial_borrow) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
         end
         ST_FIX: begin
            quotient_d    = neg_quo_q ? (~quo_q + ONE_W) : quo_q;
            remainder_d   = neg_rem_q ? (~rem_q + ONE_W) : rem_q;
            div_by_zero_d = dbz_q;
            done_d        = 1'b1;
            busy_d        = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath and output registers; reset aborts any divide in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q       <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dvs_q         <= '0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         dbz_q         <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         div_by_zero_q <= 1'b0;
      end else begin
         count_q       <= count_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         dvs_q         <= dvs_d;
         neg_quo_q     <= neg_quo_d;
         neg_rem_q     <= neg_rem_d;
         dbz_q         <= dbz_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for the iterative divider: results, latency, busy, corner cases.
// Each divide is bounded to 40 cycles.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_alu_div_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_div_seq #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   // Pulse start for one edge and wait for done; lat counts edges after the accepting one.
   task automatic run_div(input logic s, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int bcnt, output logic [15:0] q_at_start);
      is_signed = s;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      lat        = 0;
      bcnt       = 0;
      q_at_start = quotient;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      #2;
      checks++; if (quotient !== 16'h0)   begin errors++; $display("FAIL reset quotient got %h want 0000", quotient); end
      checks++; if (remainder !== 16'h0)  begin errors++; $display("FAIL reset remainder got %h want 0000", remainder); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset done got %b want 0", done); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset div_by_zero got %b want 0", div_by_zero); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned();
      logic [15:0] a_v[4], b_v[4], q_v[4], r_v[4];
      int lat, bcnt;
      logic [15:0] q0;
      a_v = '{16'd100, 16'hFFFF, 16'd7,   16'd50000};
      b_v = '{16'd7,   16'h0001, 16'd100, 16'd3};
      q_v = '{16'd14,  16'hFFFF, 16'd0,   16'd16666};
      r_v = '{16'd2,   16'h0000, 16'd7,   16'd2};
      for (int i = 0; i < 4; i++) begin
         run_div(1'b0, a_v[i], b_v[i], lat, bcnt, q0);
         checks++; if (lat != 17)            begin errors++; $display("FAIL unsigned[%0d] latency got %0d want 17", i, lat); end
         checks++; if (bcnt != 17)           begin errors++; $display("FAIL unsigned[%0d] busy cycles got %0d want 17", i, bcnt); end
         checks++; if (quotient !== q_v[i])  begin errors++; $display("FAIL unsigned[%0d] quotient got %h want %h", i, quotient, q_v[i]); end
         checks++; if (remainder !== r_v[i]) begin errors++; $display("FAIL unsigned[%0d] remainder got %h want %h", i, remainder, r_v[i]); end
         checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL unsigned[%0d] div_by_zero got %b want 0", i, div_by_zero); end
         checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL unsigned[%0d] busy at done got %b want 0", i, busy); end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0)        begin errors++; $display("FAIL unsigned[%0d] done second cycle got %b want 0", i, done); end
         checks++; if (quotient !== q_v[i])  begin errors++; $display("FAIL unsigned[%0d] quotient held got %h want %h", i, quotient, q_v[i]); end
      end
   endtask

   task automatic test_signed();
      logic [15:0] a_v[5], b_v[5], q_v[5], r_v[5];
      int lat, bcnt;
      logic [15:0] q0;
      a_v = '{16'hFF9C, 16'd100,  16'h8000, 16'hFFF9, 16'hFF9C};
      b_v = '{16'd7,    16'hFFF9, 16'hFFFF, 16'd100,  16'hFFF9};
      q_v = '{16'hFFF2, 16'hFFF2, 16'h8000, 16'h0000, 16'd14};
      r_v = '{16'hFFFE, 16'h0002, 16'h0000, 16'hFFF9, 16'hFFFE};
      for (int i = 0; i < 5; i++) begin
         run_div(1'b1, a_v[i], b_v[i], lat, bcnt, q0);
         checks++; if (lat != 17)            begin errors++; $display("FAIL signed[%0d] latency got %0d want 17", i, lat); end
         checks++; if (quotient !== q_v[i])  begin errors++; $display("FAIL signed[%0d] quotient got %h want %h", i, quotient, q_v[i]); end
         checks++; if (remainder !== r_v[i]) begin errors++; $display("FAIL signed[%0d] remainder got %h want %h", i, remainder, r_v[i]); end
         checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL signed[%0d] div_by_zero got %b want 0", i, div_by_zero); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div_zero();
      logic        s_v[3];
      logic [15:0] a_v[3];
      int lat, bcnt;
      logic [15:0] q0;
      s_v = '{1'b0, 1'b1, 1'b1};
      a_v = '{16'h1234, 16'h1234, 16'h8765};
      for (int i = 0; i < 3; i++) begin
         run_div(s_v[i], a_v[i], 16'h0000, lat, bcnt, q0);
         checks++; if (lat != 1)             begin errors++; $display("FAIL dbz[%0d] latency got %0d want 1", i, lat); end
         checks++; if (bcnt != 1)            begin errors++; $display("FAIL dbz[%0d] busy cycles got %0d want 1", i, bcnt); end
         checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dbz[%0d] quotient got %h want ffff", i, quotient); end
         checks++; if (remainder !== a_v[i]) begin errors++; $display("FAIL dbz[%0d] remainder got %h want %h", i, remainder, a_v[i]); end
         checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz[%0d] div_by_zero got %b want 1", i, div_by_zero); end
         @(posedge clk); #1;
         checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz[%0d] flag held got %b want 1", i, div_by_zero); end
      end
      run_div(1'b0, 16'd100, 16'd7, lat, bcnt, q0);
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz clear flag got %b want 0", div_by_zero); end
      checks++; if (quotient !== 16'd14)  begin errors++; $display("FAIL dbz clear quotient got %h want 000e", quotient); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      logic [15:0] q0;
      is_signed = 1'b0; dividend = 16'd50000; divisor = 16'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (lat == 3 || lat == 10) begin
            start = 1'b1; dividend = 16'd1; divisor = 16'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      checks++; if (lat != 17)              begin errors++; $display("FAIL b2b first latency got %0d want 17", lat); end
      checks++; if (quotient !== 16'd16666) begin errors++; $display("FAIL b2b first quotient got %0d want 16666", quotient); end
      checks++; if (remainder !== 16'd2)    begin errors++; $display("FAIL b2b first remainder got %0d want 2", remainder); end
      // Issue the next divide in the done cycle.
      run_div(1'b0, 16'd9, 16'd4, lat, bcnt, q0);
      checks++; if (q0 !== 16'd16666)    begin errors++; $display("FAIL b2b quotient before fix got %0d want 16666", q0); end
      checks++; if (lat != 17)           begin errors++; $display("FAIL b2b second latency got %0d want 17", lat); end
      checks++; if (quotient !== 16'd2)  begin errors++; $display("FAIL b2b second quotient got %0d want 2", quotient); end
      checks++; if (remainder !== 16'd1) begin errors++; $display("FAIL b2b second remainder got %0d want 1", remainder); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL b2b done after second got %b want 0", done); end
   endtask

   task automatic test_reset_abort();
      int lat, bcnt, dcnt;
      logic [15:0] q0;
      is_signed = 1'b0; dividend = 16'd100; divisor = 16'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++; if (quotient !== 16'h0)  begin errors++; $display("FAIL abort quotient got %h want 0000", quotient); end
      checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL abort remainder got %h want 0000", remainder); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort busy got %b want 0", busy); end
      dcnt = 0;
      repeat (3) begin @(posedge clk); #1; if (done === 1'b1) dcnt++; end
      rst_n = 1'b1;
      repeat (15) begin @(posedge clk); #1; if (done === 1'b1) dcnt++; end
      checks++; if (dcnt != 0)           begin errors++; $display("FAIL abort done pulses got %0d want 0", dcnt); end
      run_div(1'b0, 16'd100, 16'd7, lat, bcnt, q0);
      checks++; if (lat != 17)            begin errors++; $display("FAIL abort rerun latency got %0d want 17", lat); end
      checks++; if (quotient !== 16'd14)  begin errors++; $display("FAIL abort rerun quotient got %h want 000e", quotient); end
      checks++; if (remainder !== 16'd2)  begin errors++; $display("FAIL abort rerun remainder got %h want 0002", remainder); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
Iterative restoring divider for the ALU. It is the inverse of the adder path: it repeatedly subtracts using a borrow-lookahead subtractor built from the same generate/propagate scheme as the carry-lookahead adder. It accepts a start pulse, produces one quotient bit per cycle, and returns quotient and remainder with a one-cycle done pulse. It sits beside the adder in the ALU and is stalled on by the control unit via busy.

Parameters:
WIDTH, 16, operand/result width in bits (must be a multiple of 4, minimum 4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a divide; sampled only in IDLE
is_signed  input  1  1 = two's-complement divide, 0 = unsigned; captured with start
dividend  input  WIDTH  numerator; captured with start
divisor  input  WIDTH  denominator; captured with start
quotient  output  WIDTH  result quotient; held until the next accepted start
remainder  output  WIDTH  result remainder; held until the next accepted start
busy  output  1  high from the cycle after start is accepted until the result cycle
done  output  1  one-cycle pulse, aligned with quotient/remainder becoming valid
div_by_zero  output  1  registered flag for the last result; valid when done=1, held after

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; all internal registers cleared. Asserting reset mid-operation aborts the divide; no done pulse is issued.
- States: IDLE, CALC, FIX.
- IDLE: on start=1 at edge E0:
  - Capture operands. In signed mode, store magnitudes |dividend| and |divisor|, plus sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Set busy=1 and clear done.
  - If divisor==0, go to FIX. Otherwise load count=WIDTH and partial remainder=0, then go to CALC.
- CALC: one iteration per edge, for WIDTH edges (E1..E_WIDTH).
  - Shift {rem, quo} left by 1.
  - Compute trial = rem_shifted - divisor_mag using a (WIDTH+1)-bit borrow-lookahead subtract.
  - If no borrow: rem = trial and quo LSB = 1. Otherwise: rem is kept and quo LSB = 0.
  - Decrement count. When count reaches 1 on this edge, the next state is FIX.
- FIX: single edge (E_WIDTH+1 for a normal divide, E1 for divide-by-zero).
  - Apply sign correction: negate quo if sign_q, negate rem if sign_r.
  - Register quotient/remainder, assert done=1, deassert busy, return to IDLE.
- Latency: done is high in the cycle following edge E_WIDTH+1, i.e. WIDTH+1 cycles after start is sampled. A divide-by-zero returns 1 cycle after start.
- Divide-by-zero: quotient = all ones; remainder = the original dividend, unmodified in both modes; div_by_zero=1. For any other result div_by_zero=0.
- Signed overflow (dividend = most-negative value, divisor = -1): quotient = most-negative value, remainder = 0. This falls out of the magnitude algorithm plus wrap-around negation; no special flag.
- Start while busy (CALC/FIX) is ignored and not queued.
- Start in the same cycle that done is high is accepted normally (back-to-back divides). A new start does not clear quotient/remainder until its own FIX.
- Remainder sign always follows the dividend (truncating division); |remainder| < |divisor|.
- done never asserts in consecutive cycles.

Decomposition:
- Shared include/package: state encodings (IDLE, CALC, FIX), the default WIDTH, and the counter width localparam = clog2(WIDTH)+1.
- One natural sub-module: div_sub_cla. It is a combinational (WIDTH+1)-bit subtractor (A + ~B + 1) built from 4-bit lookahead groups with group propagate/generate, and it outputs difference and borrow. It is instantiated once in the CALC datapath.

Test Plan:
- Unsigned 100 / 7 (WIDTH=16) -> done exactly 17 cycles after start; quotient=14, remainder=2, div_by_zero=0; busy high for 17 cycles.
- Signed -100 / 7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2); signed 100 / -7 -> quotient=0xFFF2, remainder=0x0002.
- Divide-by-zero 0x1234 / 0 (either mode) -> done 1 cycle after start; quotient=0xFFFF, remainder=0x1234, div_by_zero=1; the next valid divide clears the flag.
- Signed 0x8000 / 0xFFFF -> quotient=0x8000, remainder=0; unsigned 0xFFFF / 0x0001 -> quotient=0xFFFF, remainder=0.
- start re-pulsed at cycles 3 and 10 of a 50000/3 divide -> ignored; single done with quotient=16666, remainder=2. Then start in the done cycle with 9/4 -> accepted, and 17 cycles later quotient=2, remainder=1.
- rst_n pulled low at cycle 8 of a divide -> outputs zero immediately, busy=0, no done pulse. start after release -> normal result.
